// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg -- shared UART frame definitions for the transmit and receive paths.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic c_start_bit = 1'b0;
    localparam logic c_stop_bit  = 1'b1;
    localparam logic c_line_idle = 1'b1;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
//------------------------------------------------------------------------------
// uart_baud_tick -- bit-period counter, one-cycle tick at the end of each period.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic restart_in,
    output logic tick_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_in) begin
        if (rst_in || restart_in || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A restart edge begins a fresh period, so it must never also end one.
    assign tick_out = (count == LAST) && !restart_in;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx -- valid/ready UART transmitter: start, data LSB first, parity, stop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 busy_out
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    tx_state_t            state, state_nx;
    logic [DATA_BITS-1:0] shift_reg, shift_nx;
    logic [IW-1:0]        bit_idx, bit_idx_nx;
    logic                 parity_bit, parity_nx;
    logic                 tx_nx;
    logic                 accept;
    logic                 tick;

    assign ready_out = (state == IDLE);
    assign busy_out  = ~ready_out;
    assign accept    = valid_in && ready_out;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .restart_in (accept),
        .tick_out   (tick)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            tx_out     <= c_line_idle;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_idx    <= bit_idx_nx;
            parity_bit <= parity_nx;
            tx_out     <= tx_nx;
        end
    end

    // tx_out is registered, so each branch computes the level for the next cycle.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_reg;
        bit_idx_nx = bit_idx;
        parity_nx  = parity_bit;
        tx_nx      = tx_out;
        case (state)
            IDLE: begin
                tx_nx      = c_line_idle;
                bit_idx_nx = '0;
                if (valid_in) begin
                    state_nx  = START;
                    shift_nx  = data_in;
                    parity_nx = (^data_in) ^ PARITY_ODD[0];
                    tx_nx     = c_start_bit;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                    tx_nx    = shift_reg[0];
                    shift_nx = shift_reg >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_nx = '0;
                        if (PARITY_EN != 0) begin
                            state_nx = PARITY;
                            tx_nx    = parity_bit;
                        end else begin
                            state_nx = STOP;
                            tx_nx    = c_stop_bit;
                        end
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                        tx_nx      = shift_reg[0];
                        shift_nx   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                    tx_nx    = c_stop_bit;
                end
            end
            STOP: begin
                // bit_idx is reused here to count stop-bit periods.
                if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        state_nx   = IDLE;
                        bit_idx_nx = '0;
                        tx_nx      = c_line_idle;
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = c_line_idle;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx -- directed checks of uart_tx at 10 clocks per bit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] ready;
    logic [3:0] tx;
    logic [3:0] busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD)) u_8n1 (
        .clk_in(clk), .rst_in(rst), .data_in(data[0]), .valid_in(valid[0]),
        .ready_out(ready[0]), .tx_out(tx[0]), .busy_out(busy[0]));
    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk_in(clk), .rst_in(rst), .data_in(data[1]), .valid_in(valid[1]),
        .ready_out(ready[1]), .tx_out(tx[1]), .busy_out(busy[1]));
    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk_in(clk), .rst_in(rst), .data_in(data[2]), .valid_in(valid[2]),
        .ready_out(ready[2]), .tx_out(tx[2]), .busy_out(busy[2]));
    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .STOP_BITS(2)) u_8n2 (
        .clk_in(clk), .rst_in(rst), .data_in(data[3]), .valid_in(valid[3]),
        .ready_out(ready[3]), .tx_out(tx[3]), .busy_out(busy[3]));

    // Line level at cycle k (1-based) of a frame: 10 cycles per bit.
    function automatic logic exp_bit(input logic [7:0] dat, input int par_en,
                                     input int odd, input int k);
        int b;
        b = (k - 1) / 10;
        if (b == 0) return 1'b0;
        if (b <= 8) return dat[b-1];
        if (par_en != 0 && b == 9) return (^dat) ^ odd[0];
        return 1'b1;
    endfunction

    function automatic logic [255:0] build_tx(input logic [7:0] dat, input int par_en,
                                              input int odd, input int len, input int ncyc);
        logic [255:0] v;
        v = '0;
        for (int i = 1; i <= ncyc; i++) v[i] = (i <= len) ? exp_bit(dat, par_en, odd, i) : 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] build_rdy(input int len, input int ncyc);
        logic [255:0] v;
        v = '0;
        for (int i = 1; i <= ncyc; i++) v[i] = (i > len);
        return v;
    endfunction

    function automatic logic [255:0] build_bsy(input int len, input int ncyc);
        logic [255:0] v;
        v = '0;
        for (int i = 1; i <= ncyc; i++) v[i] = (i <= len);
        return v;
    endfunction

    // Offers one word, then records cycles 1..ncyc after the accepting edge.
    task automatic run_frame(input int d, input logic [7:0] dat, input int ncyc,
                             output logic [255:0] otx, output logic [255:0] ordy,
                             output logic [255:0] obsy);
        otx = '0; ordy = '0; obsy = '0;
        @(negedge clk);
        valid[d] = 1'b1;
        data[d]  = dat;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (i == 1) valid[d] = 1'b0;
            otx[i]  = tx[d];
            ordy[i] = ready[d];
            obsy[i] = busy[d];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            total++;
            if ({tx[d], ready[d], busy[d]} !== 3'b110) begin
                bad++;
                $display("FAIL reset_state dut%0d got tx/rdy/bsy=%b exp=110", d,
                         {tx[d], ready[d], busy[d]});
            end
        end
        valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [255:0] otx, ordy, obsy;
        run_frame(0, 8'hA5, 101, otx, ordy, obsy);
        total++;
        if (otx !== build_tx(8'hA5, 0, 0, 100, 101)) begin
            bad++; $display("FAIL 8n1_tx got=%h exp=%h", otx, build_tx(8'hA5, 0, 0, 100, 101));
        end
        total++;
        if (ordy !== build_rdy(100, 101)) begin
            bad++; $display("FAIL 8n1_ready got=%h exp=%h", ordy, build_rdy(100, 101));
        end
        total++;
        if (obsy !== build_bsy(100, 101)) begin
            bad++; $display("FAIL 8n1_busy got=%h exp=%h", obsy, build_bsy(100, 101));
        end
        total++;
        if (otx[20:1] !== 20'hFFC00) begin
            bad++; $display("FAIL 8n1_start_bit0 got=%h exp=ffc00", otx[20:1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] otx, ordy, etx, erdy;
        otx = '0; ordy = '0; etx = '0; erdy = '0;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        for (int i = 1; i <= 203; i++) begin
            @(negedge clk);
            otx[i]  = tx[0];
            ordy[i] = ready[0];
            if (i == 1) data[0] = 8'hFF;
            if (i == 102) valid[0] = 1'b0;
        end
        for (int i = 1; i <= 203; i++) begin
            if (i <= 100) etx[i] = exp_bit(8'h00, 0, 0, i);
            else if (i >= 102 && i <= 201) etx[i] = exp_bit(8'hFF, 0, 0, i - 101);
            else etx[i] = 1'b1;
            erdy[i] = (i == 101) || (i >= 202);
        end
        total++;
        if (otx !== etx) begin
            bad++; $display("FAIL b2b_tx got=%h exp=%h", otx, etx);
        end
        total++;
        if (ordy !== erdy) begin
            bad++; $display("FAIL b2b_ready got=%h exp=%h", ordy, erdy);
        end
        total++;
        if (otx[103:100] !== 4'b0011) begin
            bad++; $display("FAIL b2b_gap got=%b exp=0011", otx[103:100]);
        end
    endtask

    task automatic test_parity();
        logic [255:0] otx, ordy, obsy;
        logic [9:0]   exp_par;
        for (int d = 1; d <= 2; d++) begin
            run_frame(d, 8'h07, 111, otx, ordy, obsy);
            exp_par = (d == 1) ? 10'h3FF : 10'h000;
            total++;
            if (otx !== build_tx(8'h07, 1, d - 1, 110, 111)) begin
                bad++; $display("FAIL parity_tx dut%0d got=%h exp=%h", d, otx,
                                build_tx(8'h07, 1, d - 1, 110, 111));
            end
            total++;
            if (ordy !== build_rdy(110, 111)) begin
                bad++; $display("FAIL parity_ready dut%0d got=%h exp=%h", d, ordy, build_rdy(110, 111));
            end
            total++;
            if (otx[100:91] !== exp_par) begin
                bad++; $display("FAIL parity_bit dut%0d got=%h exp=%h", d, otx[100:91], exp_par);
            end
        end
    endtask

    task automatic test_two_stop();
        logic [255:0] otx, ordy, obsy;
        run_frame(3, 8'h3C, 111, otx, ordy, obsy);
        total++;
        if (otx !== build_tx(8'h3C, 0, 0, 110, 111)) begin
            bad++; $display("FAIL stop2_tx got=%h exp=%h", otx, build_tx(8'h3C, 0, 0, 110, 111));
        end
        total++;
        if (ordy !== build_rdy(110, 111)) begin
            bad++; $display("FAIL stop2_ready got=%h exp=%h", ordy, build_rdy(110, 111));
        end
        total++;
        if (otx[110:81] !== 30'h3FFFFC00) begin
            bad++; $display("FAIL stop2_tail got=%h exp=3ffffc00", otx[110:81]);
        end
    endtask

    task automatic test_midframe_reset();
        logic [255:0] otx, ordy, obsy;
        logic         tx35;
        logic         idle_ok;
        tx35 = 1'b1;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'h5A;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (i == 1) valid[0] = 1'b0;
            if (i == 35) tx35 = tx[0];
        end
        total++;
        if (tx35 !== 1'b0) begin
            bad++; $display("FAIL midrst_pre got=%b exp=0", tx35);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({tx[0], ready[0], busy[0]} !== 3'b110) begin
            bad++; $display("FAIL midrst_state got=%b exp=110", {tx[0], ready[0], busy[0]});
        end
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1) idle_ok = 1'b0;
        end
        total++;
        if (idle_ok !== 1'b1) begin
            bad++; $display("FAIL midrst_idle got=%b exp=1", idle_ok);
        end
        run_frame(0, 8'h3C, 101, otx, ordy, obsy);
        total++;
        if (otx !== build_tx(8'h3C, 0, 0, 100, 101)) begin
            bad++; $display("FAIL midrst_next_tx got=%h exp=%h", otx, build_tx(8'h3C, 0, 0, 100, 101));
        end
        total++;
        if (ordy !== build_rdy(100, 101)) begin
            bad++; $display("FAIL midrst_next_ready got=%h exp=%h", ordy, build_rdy(100, 101));
        end
    endtask

    task automatic test_busy_input();
        logic [255:0] otx, ordy;
        otx = '0; ordy = '0;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hC3;
        for (int i = 1; i <= 160; i++) begin
            @(negedge clk);
            otx[i]  = tx[0];
            ordy[i] = ready[0];
            if (i == 1 || i == 21 || i == 51 || i == 96 || i == 101) valid[0] = 1'b0;
            if (i == 1)  data[0] = 8'h18;
            if (i == 20 || i == 50 || i == 95 || i == 100) begin
                valid[0] = 1'b1;
                data[0]  = ~data[0];
            end
        end
        total++;
        if (otx !== build_tx(8'hC3, 0, 0, 100, 160)) begin
            bad++; $display("FAIL busy_in_tx got=%h exp=%h", otx, build_tx(8'hC3, 0, 0, 100, 160));
        end
        total++;
        if (ordy !== build_rdy(100, 160)) begin
            bad++; $display("FAIL busy_in_ready got=%h exp=%h", ordy, build_rdy(100, 160));
        end
        total++;
        if (otx[160:91] !== {70{1'b1}}) begin
            bad++; $display("FAIL busy_in_no_extra got=%h", otx[160:91]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        for (int d = 0; d < 4; d++) data[d] = 8'h00;
        test_reset();
        test_8n1();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_midframe_reset();
        test_busy_input();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
